// File: rtl/cqu_mips_pkg.sv
// rtl/cqu_mips_pkg.sv - shared constants and IF fetch state encoding
package cqu_mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0000;
  localparam int          STALL_IF         = 0;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_REQ  = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_prefetch_unit_if.sv
// rtl/if_prefetch_unit_if.sv - instruction memory req/ack bus
interface if_prefetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous prefetch FIFO with flush
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [WIDTH-1:0]       head_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(do_push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(do_pop);
      count_q  <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch_unit.sv
// rtl/if_prefetch_unit.sv - sequential instruction prefetcher with redirect flush
module if_prefetch_unit
  import cqu_mips_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  if_prefetch_unit_if.master imem,
  output logic               inst_valid,
  output logic [DATA_W-1:0]  inst,
  output logic [ADDR_W-1:0]  inst_pc
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  if_state_e         state_q;
  logic [ADDR_W-1:0] fetch_pc_q, imem_addr_q;
  logic              imem_req_q, discard_q;

  logic              push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count, count_after;
  logic [ENT_W-1:0]  fifo_head;
  logic [ADDR_W-1:0] redirect_target, next_pc;
  logic              stall_unused;

  assign stall_unused    = ^stall[5:1];
  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Redirect wins over both queue operations; a discarded response never enters the queue.
  assign push        = imem_req_q & imem.imem_ack & ~discard_q & ~redirect_valid;
  assign pop         = inst_valid & ~stall[STALL_IF] & ~redirect_valid;
  assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);
  assign next_pc     = discard_q ? fetch_pc_q : fetch_pc_q + ADDR_W'(4);

  if_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  ({fetch_pc_q, imem.imem_rdata}),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IF_IDLE;
      fetch_pc_q  <= RESET_PC;
      discard_q   <= 1'b0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (redirect_valid) begin
            fetch_pc_q <= redirect_target;
          end else if (!fifo_full) begin
            state_q     <= IF_REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc_q;
          end
        end
        IF_REQ: begin
          if (redirect_valid) begin
            fetch_pc_q <= redirect_target;
            // Response arriving with the redirect is simply dropped; otherwise wait it out.
            if (imem.imem_ack) begin
              discard_q   <= 1'b0;
              imem_addr_q <= redirect_target;
            end else begin
              discard_q <= 1'b1;
            end
          end else if (imem.imem_ack) begin
            discard_q  <= 1'b0;
            fetch_pc_q <= next_pc;
            // Only issue when the response is guaranteed a queue slot.
            if (count_after < CNT_W'(FIFO_DEPTH)) begin
              imem_addr_q <= next_pc;
            end else begin
              state_q    <= IF_IDLE;
              imem_req_q <= 1'b0;
            end
          end
        end
        default: state_q <= IF_IDLE;
      endcase
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = imem_addr_q;

  assign inst_valid = ~fifo_empty;
  assign inst       = fifo_empty ? DATA_W'(INST_NOP) : fifo_head[DATA_W-1:0];
  assign inst_pc    = fifo_empty ? '0 : fifo_head[ENT_W-1:DATA_W];

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb/tb_if_prefetch_unit.sv - self-checking bench for if_prefetch_unit
module tb_if_prefetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  stall = 6'h00;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;

  logic        zero_wait = 1'b1;
  logic        ack_r = 1'b0;
  logic        force_ack = 1'b0;
  int          lat = 1;
  int          wait_cnt = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  if_prefetch_unit_if #(.ADDR_W(32), .DATA_W(32)) imem_bus ();

  logic        req, ack;
  logic [31:0] addr;
  assign req  = imem_bus.imem_req;
  assign addr = imem_bus.imem_addr;
  assign ack  = imem_bus.imem_ack;
  assign imem_bus.imem_ack   = zero_wait ? imem_bus.imem_req : (ack_r | force_ack);
  assign imem_bus.imem_rdata = imem_bus.imem_addr ^ K;

  if_prefetch_unit #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .FIFO_DEPTH (4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  // Latency memory: acks lat negedges after a request appears, then clears.
  always @(negedge clk) begin
    if (!rstn || zero_wait || !req || ack_r) begin
      ack_r    = 1'b0;
      wait_cnt = 0;
    end else begin
      wait_cnt++;
      if (wait_cnt >= lat) ack_r = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input bit hold_stall);
    rstn = 1'b0;
    redirect_valid = 1'b0;
    force_ack = 1'b0;
    stall = hold_stall ? 6'h01 : 6'h00;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%0b exp=0", req); end
    n_cmp++; if (addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=0", addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0b exp=0", inst_valid); end
    n_cmp++; if (inst !== 32'h0) begin n_fail++; $display("FAIL rst_inst got=%h exp=0", inst); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc got=%h exp=0", inst_pc); end
  endtask

  task automatic test_zero_wait();
    zero_wait = 1'b1;
    do_reset(1'b0);
    tick();
    n_cmp++; if (req !== 1'b1 || addr !== 32'h0) begin n_fail++; $display("FAIL zw_first_req got=%0b/%h exp=1/0", req, addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL zw_startup_valid got=%0b exp=0", inst_valid); end
    tick();
    for (int i = 0; i < 10; i++) begin
      logic [31:0] e;
      e = 32'(4 * i);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== e || inst !== (e ^ K)) begin
        n_fail++;
        $display("FAIL zw_stream[%0d] got=%0b/%h/%h exp=1/%h/%h", i, inst_valid, inst_pc, inst, e, e ^ K);
      end
      tick();
    end
  endtask

  task automatic test_stall_fill();
    bit got_req;
    zero_wait = 1'b1;
    do_reset(1'b1);
    repeat (10) tick();
    n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL sf_req_dropped got=%0b exp=0", req); end
    stall = 6'h00;
    got_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] e;
      e = 32'(4 * i);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== e || inst !== (e ^ K)) begin
        n_fail++;
        $display("FAIL sf_pop[%0d] got=%0b/%h/%h exp=1/%h/%h", i, inst_valid, inst_pc, inst, e, e ^ K);
      end
      if (!got_req && req === 1'b1) begin
        got_req = 1'b1;
        n_cmp++; if (addr !== 32'h10) begin n_fail++; $display("FAIL sf_resume_addr got=%h exp=00000010", addr); end
      end
      tick();
    end
    n_cmp++; if (!got_req) begin n_fail++; $display("FAIL sf_resume got=no_request exp=request"); end
  endtask

  task automatic test_redirect_pending();
    int g;
    zero_wait = 1'b0;
    lat = 3;
    do_reset(1'b0);
    g = 0;
    while (!(req === 1'b1 && addr === 32'h8) && g < 60) begin tick(); g++; end
    n_cmp++; if (g >= 60) begin n_fail++; $display("FAIL rp_reach8 got=timeout exp=req_at_8"); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (req !== 1'b1 || addr !== 32'h8) begin n_fail++; $display("FAIL rp_hold got=%0b/%h exp=1/00000008", req, addr); end
    g = 0;
    while (req === 1'b1 && addr === 32'h8 && g < 20) begin
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rp_flushed got=%0b/%h exp=0", inst_valid, inst_pc); end
      tick();
      g++;
    end
    n_cmp++; if (req !== 1'b1 || addr !== 32'h100) begin n_fail++; $display("FAIL rp_new_req got=%0b/%h exp=1/00000100", req, addr); end
    g = 0;
    while (inst_valid !== 1'b1 && g < 20) begin tick(); g++; end
    n_cmp++; if (inst_pc !== 32'h100 || inst !== (32'h100 ^ K)) begin n_fail++; $display("FAIL rp_first_inst got=%h/%h exp=00000100/%h", inst_pc, inst, 32'h100 ^ K); end
  endtask

  task automatic test_redirect_ack_pop();
    zero_wait = 1'b1;
    do_reset(1'b0);
    repeat (4) tick();
    n_cmp++; if (inst_valid !== 1'b1 || ack !== 1'b1) begin n_fail++; $display("FAIL rap_steady got=%0b/%0b exp=1/1", inst_valid, ack); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rap_empty got=%0b/%h exp=0", inst_valid, inst_pc); end
    n_cmp++; if (req !== 1'b1 || addr !== 32'h200) begin n_fail++; $display("FAIL rap_req got=%0b/%h exp=1/00000200", req, addr); end
    tick();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin n_fail++; $display("FAIL rap_first got=%0b/%h exp=1/00000200", inst_valid, inst_pc); end
  endtask

  task automatic test_wrap();
    zero_wait = 1'b1;
    do_reset(1'b0);
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wr_addr got=%h exp=fffffff8", addr); end
    tick();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      e = 32'hFFFF_FFF8 + 32'(4 * i);
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== e || inst !== (e ^ K)) begin
        n_fail++;
        $display("FAIL wr_seq[%0d] got=%0b/%h/%h exp=1/%h/%h", i, inst_valid, inst_pc, inst, e, e ^ K);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int g;
    zero_wait = 1'b0;
    lat = 3;
    do_reset(1'b0);
    g = 0;
    while (!(req === 1'b1 && addr === 32'h20) && g < 80) begin tick(); g++; end
    n_cmp++; if (g >= 80) begin n_fail++; $display("FAIL rm_reach20 got=timeout exp=req_at_20"); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (req !== 1'b0 || addr !== 32'h0) begin n_fail++; $display("FAIL rm_async_bus got=%0b/%h exp=0/0", req, addr); end
    n_cmp++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL rm_async_out got=%0b/%h/%h exp=0/0/0", inst_valid, inst, inst_pc); end
    tick();
    tick();
    rstn = 1'b1;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    n_cmp++; if (req !== 1'b1 || addr !== 32'h0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rm_late_ack got=%0b/%h/%0b exp=1/0/0", req, addr, inst_valid); end
    g = 0;
    while (inst_valid !== 1'b1 && g < 20) begin tick(); g++; end
    n_cmp++; if (inst_pc !== 32'h0 || inst !== K) begin n_fail++; $display("FAIL rm_first got=%h/%h exp=0/%h", inst_pc, inst, K); end
  endtask

  // Reference: popped entries form a +4 stream restarting at every redirect target.
  task automatic test_random(input bit zw, input int ncyc);
    logic [31:0] exp_pc, prev_addr;
    bit          prev_pend, s0;
    int          pops;
    zero_wait = zw;
    do_reset(1'b0);
    exp_pc = 32'h0;
    pops = 0;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
    for (int c = 0; c < ncyc; c++) begin
      lat = $urandom_range(1, 3);
      if (prev_pend) begin
        n_cmp++;
        if (req !== 1'b1 || addr !== prev_addr) begin n_fail++; $display("FAIL rnd_hold c=%0d got=%0b/%h exp=1/%h", c, req, addr, prev_addr); end
      end
      if (inst_valid === 1'b0) begin
        n_cmp++;
        if (inst !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL rnd_nop c=%0d got=%h/%h exp=0/0", c, inst, inst_pc); end
      end
      s0 = ($urandom_range(0, 99) < 30);
      stall = {5'($urandom()), s0};
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc = $urandom();
      if (redirect_valid) begin
        exp_pc = redirect_pc & ~32'h3;
      end else if (inst_valid === 1'b1 && !s0) begin
        n_cmp++;
        if (inst_pc !== exp_pc || inst !== (exp_pc ^ K)) begin
          n_fail++;
          $display("FAIL rnd_pop c=%0d got=%h/%h exp=%h/%h", c, inst_pc, inst, exp_pc, exp_pc ^ K);
        end
        exp_pc = exp_pc + 32'h4;
        pops++;
      end
      prev_pend = (req === 1'b1) && (ack !== 1'b1);
      prev_addr = addr;
      tick();
    end
    redirect_valid = 1'b0;
    stall = 6'h00;
    n_cmp++; if (pops < ncyc / 8) begin n_fail++; $display("FAIL rnd_progress got=%0d exp>=%0d", pops, ncyc / 8); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_fill();
    test_redirect_pending();
    test_redirect_ack_pop();
    test_wrap();
    test_reset_mid();
    test_random(1'b1, 400);
    test_random(1'b0, 600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Parametrised successor to the single-register fetch stage. Fetches sequential instructions from an external instruction memory using a req/ack handshake, buffers them in a FIFO_DEPTH-entry prefetch queue with their PCs, and presents the queue head to ID. It accepts branch/jump redirects that flush the queue and discard any in-flight response, and it honours the pipeline stall vector (stall[0] = IF/ID hold).

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width
FIFO_DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
clk  in  1  clock; all state updates on posedge
rstn  in  1  asynchronous active-low reset
stall  in  6  pipeline stall vector; only stall[0] used here
redirect_valid  in  1  one-cycle pulse: flush and refetch from redirect_pc
redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
imem_req  out  1  read request, registered
imem_addr  out  ADDR_W  word-aligned read address, registered, stable while imem_req=1
imem_ack  in  1  response valid; completes transaction when imem_req=1
imem_rdata  in  DATA_W  instruction word, valid with imem_ack
inst_valid  out  1  queue non-empty
inst  out  DATA_W  head instruction; 0 (NOP) when empty
inst_pc  out  ADDR_W  head PC; 0 when empty

Behaviour:
- Reset (async, rstn=0): fetch_pc=RESET_PC, queue empty, state IDLE, discard=0; imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- Handshake: transaction completes at the edge where imem_req&&imem_ack. imem_req never retracts before ack; addr held. Ack with imem_req=0 is ignored. One outstanding request max.
- FSM states:
  IDLE: if (count+0)<FIFO_DEPTH and no redirect -> REQ; imem_req<=1, imem_addr<=fetch_pc.
  REQ: waiting for ack. On ack: if discard=0, push {fetch_pc, imem_rdata}, fetch_pc+=4; if discard=1, drop data, clear discard. Next: if space (count after this edge < FIFO_DEPTH) issue next request back-to-back (stay REQ, new addr), else IDLE with imem_req<=0.
- Space rule: issue only when count + outstanding < FIFO_DEPTH, so a response always has a slot.
- Pop: head consumed at edge where inst_valid=1 and stall[0]=0. Simultaneous push+pop: count unchanged. Pushed entry visible on outputs the cycle after the edge (no bypass).
- Redirect (highest priority over pop and push): queue flushed (count=0), fetch_pc<=redirect_pc&~3. If a request is outstanding and not acked that edge, set discard=1 and keep imem_req/addr unchanged until ack; then issue to new fetch_pc. If the ack coincides with redirect, data dropped, discard stays 0, next request to redirect target. If no request outstanding, request to target issued on next edge. Redirect while discard=1: target updated, discard remains 1. Redirect is accepted regardless of stall.
- stall[0]=1: no pop; fetching continues until queue full.
- fetch_pc wraps modulo 2^ADDR_W (FFFF_FFFC+4 -> 0000_0000).
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally; count has one extra bit.
- Reset mid-transaction: all state cleared immediately; outstanding memory response after reset release is ignored (imem_req=0).

Decomposition:
- Shared package cqu_mips_pkg: RESET_PC default, INST_NOP=32'h0, IF FSM state encoding (IDLE, REQ), STALL_IF index=0.
- Sub-module if_fifo: synchronous FIFO of {pc,inst}, ports push/pop/flush/full/empty/count; parametrised width and depth.

Test Plan:
- Zero-wait memory (ack tied to req), rdata=addr^32'hA5A5_0000, stall=0: inst_pc sequence 0,4,8,... one per cycle after 2-cycle startup; inst matches.
- stall[0]=1 for 10 cycles, FIFO_DEPTH=4: exactly 4 entries buffered, imem_req drops to 0; release -> entries 0,4,8,C pop in order, fetch resumes at 0x10.
- Memory latency 3 cycles, redirect to 0x0000_0102 while request at 0x8 pending: imem_addr held 0x8 until ack, its data dropped, next request 0x0000_0100, first inst_pc=0x100.
- Redirect coincident with ack and a pop: queue empty next cycle, no entry for old addr, next request = target.
- redirect_pc=0xFFFF_FFF8, zero-wait: inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rstn low mid-request at addr 0x20: outputs return to reset values asynchronously; after release first request at RESET_PC, late ack ignored.
